mem_port_arbiter: RTL and testbench

// - Shares the single-port data/instruction memory between the processor (port C, driven by the

---
 rtl/tf_mem_pkg.sv | 26 ++
 rtl/rd_tag_pipe.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tf_mem_pkg.sv
// ---------------------------------------------------------------------------
// tf_mem_pkg
// Shared definitions for the memory port arbiter slice.
//   PORT_C / PORT_D : port identifiers carried through the read-tag pipe and
//                     used as the round-robin "last granted" marker
//   arbState_t      : arbitration FSM state encoding (ARB / BURST)
//   rdTag_t         : one in-flight read tag {valid, port}
//   MAX_RD_LAT      : deepest read latency the tag pipe is built for
// ---------------------------------------------------------------------------
package tf_mem_pkg;

   localparam logic PORT_C     = 1'b0;
   localparam logic PORT_D     = 1'b1;
   localparam int   MAX_RD_LAT = 4;

   typedef enum logic {
      ARB   = 1'b0,
      BURST = 1'b1
   } arbState_t;

   typedef struct packed {
      logic valid;
      logic port;
   } rdTag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// ---------------------------------------------------------------------------
// rd_tag_pipe
// Fixed-depth shift register that follows each read through the memory's
// read latency, so the returning data can be steered to the port that
// issued it.
//   clk, reset : clock and synchronous active-high clear
//   push       : a read was accepted this cycle
//   pushPort   : which port issued that read
//   popValid   : a read issued RD_LAT cycles ago returns now
//   popPort    : the port that read belongs to
// ---------------------------------------------------------------------------
module rd_tag_pipe
   import tf_mem_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  logic pushPort,
   output logic popValid,
   output logic popPort
);

   rdTag_t stage [RD_LAT];

   // Every cycle a tag (possibly an empty one) enters stage 0 and the rest
   // move one step along; clearing on reset drops reads still in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < RD_LAT; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0].valid <= push;
         stage[0].port  <= pushPort;
         for (int i = 1; i < RD_LAT; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign popValid = stage[RD_LAT-1].valid;
   assign popPort  = stage[RD_LAT-1].port;

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port synchronous memory between the processor (port C)
// and a peripheral master (port D). Round-robin between the two, with an
// optional locked burst for D that C can break after MAX_BURST beats.
//   clk, reset                      : clock, synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata       : processor request (held until c_gnt)
//   c_gnt, c_rvalid, c_rdata        : processor accept and read return
//   d_req/d_lock/d_we/d_addr/d_wdata: peripheral request, d_lock asks for a burst
//   d_gnt, d_rvalid, d_rdata        : peripheral accept and read return
//   mem_en/mem_we/mem_addr/mem_wdata: memory strobe and muxed request
//   mem_rdata                       : memory data, RD_LAT cycles after a read
// ---------------------------------------------------------------------------
module mem_port_arbiter
   import tf_mem_pkg::*;
#(
   parameter int AW        = 16,
   parameter int DW        = 16,
   parameter int RD_LAT    = 1,
   parameter int MAX_BURST = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic          c_gnt,
   output logic          c_rvalid,
   output logic [DW-1:0] c_rdata,
   input  logic          d_req,
   input  logic          d_lock,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   // Latency outside 1..MAX_RD_LAT is not supported; clamp so the pipe is
   // always buildable.
   localparam int TAG_DEPTH = (RD_LAT < 1) ? 1 :
                              (RD_LAT > MAX_RD_LAT) ? MAX_RD_LAT : RD_LAT;
   localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

   arbState_t  state, nextState;
   logic       lastPort, nextLast;
   logic [7:0] burstCnt, nextCnt;
   logic       cGnt, dGnt;
   logic       atLimit;
   logic       popValid, popPort;

   assign atLimit = (burstCnt == MAX_CNT);

   // Arbitration state, round-robin marker and burst beat counter. After
   // reset last=D so the processor wins the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ARB;
         lastPort <= PORT_D;
         burstCnt <= '0;
      end else begin
         state    <= nextState;
         lastPort <= nextLast;
         burstCnt <= nextCnt;
      end
   end

   // Grant decision and next state. In BURST the processor is locked out
   // until D releases the lock or has done MAX_BURST beats while C waits;
   // the forced exit leaves an idle cycle and hands the next tie to C.
   // Grants are held off during reset so nothing reaches the memory then.
   always_comb begin
      cGnt      = 1'b0;
      dGnt      = 1'b0;
      nextState = state;
      nextLast  = lastPort;
      nextCnt   = burstCnt;
      case (state)
         ARB: begin
            if (c_req && d_req) begin
               if (lastPort == PORT_D) cGnt = 1'b1;
               else                    dGnt = 1'b1;
            end else if (c_req) begin
               cGnt = 1'b1;
            end else if (d_req) begin
               dGnt = 1'b1;
            end
            if (cGnt) nextLast = PORT_C;
            if (dGnt) begin
               nextLast = PORT_D;
               if (d_lock) begin
                  nextState = BURST;
                  nextCnt   = 8'd1;
               end
            end
         end
         BURST: begin
            nextLast = PORT_D;
            dGnt     = d_req && !(atLimit && c_req);
            if (dGnt && d_lock) begin
               if (!atLimit) nextCnt = burstCnt + 8'd1;
            end else begin
               nextState = ARB;
               nextCnt   = '0;
            end
         end
         default: begin
            nextState = ARB;
         end
      endcase
      if (reset) begin
         cGnt = 1'b0;
         dGnt = 1'b0;
      end
   end

   assign c_gnt     = cGnt;
   assign d_gnt     = dGnt;
   assign mem_en    = cGnt | dGnt;
   assign mem_we    = cGnt ? c_we    : (dGnt ? d_we    : 1'b0);
   assign mem_addr  = cGnt ? c_addr  : (dGnt ? d_addr  : '0);
   assign mem_wdata = cGnt ? c_wdata : (dGnt ? d_wdata : '0);

   rd_tag_pipe #(
      .RD_LAT(TAG_DEPTH)
   ) tagPipe (
      .clk     (clk),
      .reset   (reset),
      .push    (mem_en && !mem_we),
      .pushPort(dGnt ? PORT_D : PORT_C),
      .popValid(popValid),
      .popPort (popPort)
   );

   assign c_rvalid = popValid && (popPort == PORT_C);
   assign d_rvalid = popValid && (popPort == PORT_D);
   assign c_rdata  = mem_rdata;
   assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Three arbiters (RD_LAT = 1, 2, 3; MAX_BURST = 8) driven by the same
// stimulus, each with its own fixed-latency memory model. Grants are
// identical across instances, so grant checks use the RD_LAT=1 copy and
// read-return checks pick the instance with the latency under test.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        c_req, c_we, d_req, d_lock, d_we;
   logic [15:0] c_addr, c_wdata, d_addr, d_wdata;

   logic        cGntA     [3];
   logic        cRvalidA  [3];
   logic [15:0] cRdataA   [3];
   logic        dGntA     [3];
   logic        dRvalidA  [3];
   logic [15:0] dRdataA   [3];
   logic        memEnA    [3];
   logic        memWeA    [3];
   logic [15:0] memAddrA  [3];
   logic [15:0] memWdataA [3];
   logic [15:0] memRdataA [3];

   int totalChecks = 0;
   int badChecks   = 0;

   // Memory contents: one known word for the directed read, a fixed
   // address pattern everywhere else.
   function automatic logic [15:0] memFunc(input logic [15:0] a);
      return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
   endfunction

   // One arbiter plus a memory model whose data follows its read latency.
   for (genvar g = 0; g < 3; g++) begin : inst
      logic [15:0] addrPipe [4];

      mem_port_arbiter #(
         .AW(16), .DW(16), .RD_LAT(g + 1), .MAX_BURST(8)
      ) dut (
         .clk      (clk),
         .reset    (reset),
         .c_req    (c_req),
         .c_we     (c_we),
         .c_addr   (c_addr),
         .c_wdata  (c_wdata),
         .c_gnt    (cGntA[g]),
         .c_rvalid (cRvalidA[g]),
         .c_rdata  (cRdataA[g]),
         .d_req    (d_req),
         .d_lock   (d_lock),
         .d_we     (d_we),
         .d_addr   (d_addr),
         .d_wdata  (d_wdata),
         .d_gnt    (dGntA[g]),
         .d_rvalid (dRvalidA[g]),
         .d_rdata  (dRdataA[g]),
         .mem_en   (memEnA[g]),
         .mem_we   (memWeA[g]),
         .mem_addr (memAddrA[g]),
         .mem_wdata(memWdataA[g]),
         .mem_rdata(memRdataA[g])
      );

      initial for (int k = 0; k < 4; k++) addrPipe[k] = '0;

      always @(posedge clk) begin
         addrPipe[0] <= memAddrA[g];
         for (int k = 1; k < 4; k++) addrPipe[k] <= addrPipe[k-1];
      end

      assign memRdataA[g] = memFunc(addrPipe[g]);
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      totalChecks++;
      if (actual !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle's request inputs, then let the combinational outputs
   // settle before the caller samples them.
   task automatic applyStimulus(input logic cReq, input logic cWe,
                                input logic [15:0] cAddr, input logic [15:0] cWdata,
                                input logic dReq, input logic dLock, input logic dWe,
                                input logic [15:0] dAddr, input logic [15:0] dWdata);
      c_req   = cReq;
      c_we    = cWe;
      c_addr  = cAddr;
      c_wdata = cWdata;
      d_req   = dReq;
      d_lock  = dLock;
      d_we    = dWe;
      d_addr  = dAddr;
      d_wdata = dWdata;
      #2;
   endtask

   // Requester rule: a waiting processor request must keep its address.
   logic        cPendPrev = 1'b0;
   logic [15:0] cHeld     = '0;
   always @(negedge clk) begin
      if (cPendPrev && c_req) checkOutput("cAddrHold", c_addr, cHeld);
      cPendPrev = c_req && !cGntA[0] && !reset;
      cHeld     = c_addr;
   end

   logic [1:0]  expBurst [15] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                                  2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b01,
                                  2'b01, 2'b01, 2'b01};
   logic [1:0]  expAlt   [10] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10,
                                  2'b01, 2'b00, 2'b00, 2'b00};
   logic [1:0]  expRv    [10] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01,
                                  2'b10, 2'b01, 2'b10, 2'b01};
   logic [15:0] expData  [10] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h595A, 16'h5E5A,
                                  16'h595B, 16'h5E5B, 16'h5958, 16'h5E58};

   initial begin
      int dBeats, cIss, dIss;
      logic cDone;

      // Reset with both requesting: nothing may be granted.
      reset = 1'b1;
      applyStimulus(1, 0, 16'h0100, 0, 1, 0, 0, 16'h0200, 0);
      nextCycle();
      applyStimulus(1, 0, 16'h0100, 0, 1, 0, 0, 16'h0200, 0);
      checkOutput("rstGnt",    {cGntA[0], dGntA[0]}, 2'b00);
      checkOutput("rstMemEn",  memEnA[0], 1'b0);
      checkOutput("rstMemAdr", memAddrA[0], 16'h0000);
      checkOutput("rstRvalid", {cRvalidA[2], dRvalidA[2]}, 2'b00);

      // First tie goes to C, D follows with no bubble.
      nextCycle();
      reset = 1'b0;
      applyStimulus(1, 0, 16'h0100, 0, 1, 0, 0, 16'h0200, 0);
      checkOutput("tieGnt",  {cGntA[0], dGntA[0]}, 2'b10);
      checkOutput("tieAddr", memAddrA[0], 16'h0100);
      nextCycle();
      applyStimulus(0, 0, 16'h0100, 0, 1, 0, 0, 16'h0200, 0);
      checkOutput("tieGnt2",   {cGntA[0], dGntA[0]}, 2'b01);
      checkOutput("tieAddr2",  memAddrA[0], 16'h0200);
      checkOutput("tieCRv",    cRvalidA[0], 1'b1);
      checkOutput("tieCRdata", cRdataA[0], 16'h5B5A);
      nextCycle();
      applyStimulus(0, 0, 16'h0, 0, 0, 0, 0, 16'h0, 0);
      checkOutput("tieDRv",    {cRvalidA[0], dRvalidA[0]}, 2'b01);
      checkOutput("tieDRdata", dRdataA[0], 16'h585A);
      checkOutput("idleMemEn", memEnA[0], 1'b0);
      checkOutput("idleAddr",  memAddrA[0], 16'h0000);

      // Lone C read of 0x0010, then a C write with no response.
      nextCycle();
      applyStimulus(1, 0, 16'h0010, 0, 0, 0, 0, 16'h0, 0);
      checkOutput("cRdGnt",  {cGntA[0], dGntA[0]}, 2'b10);
      checkOutput("cRdEn",   {memEnA[0], memWeA[0]}, 2'b10);
      checkOutput("cRdAddr", memAddrA[0], 16'h0010);
      nextCycle();
      applyStimulus(1, 1, 16'h0020, 16'h1234, 0, 0, 0, 16'h0, 0);
      checkOutput("cRdRv",    {cRvalidA[0], dRvalidA[0]}, 2'b10);
      checkOutput("cRdData",  cRdataA[0], 16'hBEEF);
      checkOutput("cWrEn",    {memEnA[0], memWeA[0]}, 2'b11);
      checkOutput("cWrAddr",  memAddrA[0], 16'h0020);
      checkOutput("cWrWdata", memWdataA[0], 16'h1234);
      nextCycle();
      applyStimulus(0, 0, 16'h0, 0, 0, 0, 0, 16'h0, 0);
      checkOutput("cWrNoRv", {cRvalidA[0], dRvalidA[0]}, 2'b00);
      for (int i = 0; i < 4; i++) nextCycle();

      // 12-beat locked D burst, C waiting from beat 3: 8 beats, idle, C, rest of D.
      dBeats = 0;
      cDone  = 1'b0;
      for (int i = 1; i <= 14; i++) begin
         applyStimulus((i >= 3) && !cDone, 0, 16'h0700, 0,
                       dBeats < 12, dBeats < 11, 0, 16'h0800 + 16'(dBeats), 0);
         checkOutput($sformatf("burstGnt%0d", i), {cGntA[0], dGntA[0]}, expBurst[i]);
         if (cGntA[0]) cDone = 1'b1;
         if (dGntA[0]) dBeats++;
         nextCycle();
      end
      applyStimulus(0, 0, 16'h0, 0, 0, 0, 0, 16'h0, 0);
      checkOutput("burstBeats", dBeats, 12);
      for (int i = 0; i < 4; i++) nextCycle();

      // 4-beat burst released on beat 4; back in ARB C wins the next tie.
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(0, 0, 16'h0, 0, 1, i < 4, 0, 16'h0900 + 16'(i), 0);
         checkOutput($sformatf("shortGnt%0d", i), {cGntA[0], dGntA[0]}, 2'b01);
         nextCycle();
      end
      applyStimulus(1, 0, 16'h0A00, 0, 1, 0, 0, 16'h0905, 0);
      checkOutput("shortArb", {cGntA[0], dGntA[0]}, 2'b10);
      nextCycle();
      applyStimulus(0, 0, 16'h0, 0, 1, 0, 0, 16'h0905, 0);
      checkOutput("shortArbD", {cGntA[0], dGntA[0]}, 2'b01);
      nextCycle();
      applyStimulus(0, 0, 16'h0, 0, 0, 0, 0, 16'h0, 0);
      for (int i = 0; i < 5; i++) nextCycle();

      // Alternating C/D reads, RD_LAT=3: returns in issue order 3 cycles later.
      cIss = 0;
      dIss = 0;
      for (int i = 1; i <= 9; i++) begin
         applyStimulus(cIss < 3, 0, 16'h0300 + 16'(cIss), 0,
                       dIss < 3, 0, 0, 16'h0400 + 16'(dIss), 0);
         checkOutput($sformatf("altGnt%0d", i), {cGntA[0], dGntA[0]}, expAlt[i]);
         checkOutput($sformatf("altRv%0d", i), {cRvalidA[2], dRvalidA[2]}, expRv[i]);
         if (expRv[i] == 2'b10) checkOutput($sformatf("altCData%0d", i), cRdataA[2], expData[i]);
         if (expRv[i] == 2'b01) checkOutput($sformatf("altDData%0d", i), dRdataA[2], expData[i]);
         if (cGntA[0]) cIss++;
         if (dGntA[0]) dIss++;
         nextCycle();
      end
      applyStimulus(0, 0, 16'h0, 0, 0, 0, 0, 16'h0, 0);
      for (int i = 0; i < 4; i++) nextCycle();

      // Locked D read, reset the next cycle: tag dropped, lock gone, last=D.
      applyStimulus(0, 0, 16'h0, 0, 1, 1, 0, 16'h0500, 0);
      checkOutput("rstMidGnt", {cGntA[0], dGntA[0]}, 2'b01);
      nextCycle();
      reset = 1'b1;
      applyStimulus(1, 0, 16'h0600, 0, 0, 0, 0, 16'h0, 0);
      checkOutput("rstMidSupp", {cGntA[0], dGntA[0], memEnA[0]}, 3'b000);
      nextCycle();
      reset = 1'b0;
      applyStimulus(1, 0, 16'h0600, 0, 1, 0, 0, 16'h0501, 0);
      checkOutput("rstMidArb", {cGntA[0], dGntA[0]}, 2'b10);
      checkOutput("rstMidRv1", dRvalidA[1], 1'b0);
      nextCycle();
      applyStimulus(0, 0, 16'h0, 0, 1, 0, 0, 16'h0501, 0);
      checkOutput("rstMidD",   {cGntA[0], dGntA[0]}, 2'b01);
      checkOutput("rstMidRv2", dRvalidA[1], 1'b0);
      nextCycle();
      applyStimulus(0, 0, 16'h0, 0, 0, 0, 0, 16'h0, 0);
      checkOutput("rstMidCRv", {cRvalidA[1], dRvalidA[1]}, 2'b10);
      nextCycle();

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
